pulse_sequencer: RTL

- Synchronous controller that schedules a delayed, repeated pulse train on a single output, `signal`.
- Replaces free-running `#`-delay pulse and trigger behaviour with a counter-driven FSM, so pulse timing is programmable and synthesizable.
- Sits between a testbench or host that arms it and any downstream block that needs a timed strobe or burst.

---
 rtl/pulse_pkg.sv | 25 ++
 rtl/pulse_sequencer_down_counter.sv | 38 +++
 rtl/pulse_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pulse_pkg.sv
// pulse_pkg
// Shared definitions for the pulse sequencer slice.
//   state_t     : sequencer FSM states (IDLE, DELAY, HIGH, GAP)
//   CNT_W_DEF   : default width of the delay/width/gap counters
//   NUM_W_DEF   : default width of the pulse-count field
//   eff(x)      : maps a zero field to 1 so that "0" behaves like "1"
package pulse_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int NUM_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        HIGH  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Operates on a 32-bit value so it serves every field width;
    // callers cast their field in and truncate the result back.
    function automatic logic [31:0] eff(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

endpackage

// File: rtl/pulse_sequencer_down_counter.sv
// down_counter
// Loadable down-counter with a zero flag, shared by the DELAY, HIGH
// and GAP phases of the pulse sequencer.
// Ports:
//   clock      : system clock
//   reset_n    : asynchronous active-low reset (counter clears to 0)
//   load       : load load_value this edge (has priority over dec)
//   load_value : value to load
//   dec        : decrement by one this edge (held at 0, never wraps)
//   zero       : high while the counter holds 0
module down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load wins over decrement; decrement is suppressed at zero so the
    // value can never wrap even if the controller asks for it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// pulse_sequencer
// Counter-driven FSM that emits a delayed, repeated pulse train.
// Ports:
//   clock   : system clock, all state changes on posedge
//   reset_n : asynchronous active-low reset
//   on      : enable; dropping it mid-sequence aborts
//   start   : request, only sampled in IDLE
//   delay   : cycles from acceptance to the first rising edge of signal
//   width   : high time per pulse (0 treated as 1)
//   gap     : low time between pulses (0 treated as 1)
//   count   : pulses per sequence (0 treated as 1)
//   signal  : registered pulse train
//   busy    : high while a sequence is active
//   done    : one-cycle strobe after the last pulse completes
//   aborted : one-cycle strobe when on falls mid-sequence
module pulse_sequencer
    import pulse_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             on,
    input  logic             start,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] gap,
    input  logic [NUM_W-1:0] count,
    output logic             signal,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    state_t           state;
    logic [CNT_W-1:0] width_r;
    logic [CNT_W-1:0] gap_r;
    logic [NUM_W-1:0] pulses_left;

    logic [CNT_W-1:0] width_in_eff;
    logic [CNT_W-1:0] gap_in_eff;
    logic [NUM_W-1:0] count_in_eff;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             accept;

    assign width_in_eff = CNT_W'(eff(32'(width)));
    assign gap_in_eff   = CNT_W'(eff(32'(gap)));
    assign count_in_eff = NUM_W'(eff(32'(count)));
    assign accept       = (state == IDLE) && start && on;

    down_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (cnt_load),
        .load_value (cnt_value),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    // Counter control mirrors the FSM transitions below. At acceptance the
    // latched width is not yet available, so the zero-delay case uses the
    // live input. Leaving a sequence (abort or done) parks the counter at 0.
    always_comb begin
        cnt_load  = 1'b0;
        cnt_value = '0;
        cnt_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_load  = 1'b1;
                    cnt_value = (delay == '0) ? (width_in_eff - CNT_W'(1))
                                              : (delay - CNT_W'(1));
                end
            end
            DELAY, HIGH, GAP: begin
                if (!on) begin
                    cnt_load  = 1'b1;
                    cnt_value = '0;
                end else if (cnt_zero) begin
                    cnt_load = 1'b1;
                    if (state == HIGH) begin
                        cnt_value = (pulses_left == NUM_W'(1)) ? '0
                                                               : (gap_r - CNT_W'(1));
                    end else begin
                        cnt_value = width_r - CNT_W'(1);
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                cnt_load  = 1'b1;
                cnt_value = '0;
            end
        endcase
    end

    // Main FSM with registered outputs. done/aborted are strobes, cleared
    // every edge unless this edge's transition sets them. Abort is checked
    // before any counter-driven transition so it always wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            signal      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            width_r     <= '0;
            gap_r       <= '0;
            pulses_left <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        width_r     <= width_in_eff;
                        gap_r       <= gap_in_eff;
                        pulses_left <= count_in_eff;
                        busy        <= 1'b1;
                        if (delay == '0) begin
                            state  <= HIGH;
                            signal <= 1'b1;
                        end else begin
                            state <= DELAY;
                        end
                    end
                end
                DELAY, HIGH, GAP: begin
                    if (!on) begin
                        state   <= IDLE;
                        signal  <= 1'b0;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else if (cnt_zero) begin
                        if (state == HIGH) begin
                            signal <= 1'b0;
                            if (pulses_left == NUM_W'(1)) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state       <= GAP;
                                pulses_left <= pulses_left - NUM_W'(1);
                            end
                        end else begin
                            state  <= HIGH;
                            signal <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    signal <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
